// File: rtl/acc_dispatch_ctrl.sv
// rtl/acc_dispatch_ctrl.sv - INST_ACC sequencer: load operands, feed accelerator, store results (optional watchdog: ACC_TIMEOUT_EN)
module acc_dispatch_ctrl #(
    parameter int VEC_LEN     = 8,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        acc_instr_id,
    input  logic [2:0]  acc_funct3,
    input  logic [31:0] acc_src_addr,
    input  logic [31:0] acc_dst_addr,
    output logic        stall,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        acc_start,
    output logic [2:0]  acc_op,
    output logic        acc_in_valid,
    output logic [31:0] acc_in_data,
    input  logic        acc_in_ready,
    input  logic        acc_out_valid,
    input  logic [31:0] acc_out_data,
    output logic        acc_out_ready,
    output logic        acc_error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_REQ  = 3'd1,
        S_LD_PUSH = 3'd2,
        S_ST_POP  = 3'd3,
        S_ST_REQ  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Reject parameter sets where the index counter cannot reach the last word.
    if (((1 << CNT_W) < VEC_LEN) || (CNT_W > 30) || (VEC_LEN < 1) || (TIMEOUT_CYC < 1)) begin : g_param_check
        $error("acc_dispatch_ctrl: illegal VEC_LEN/CNT_W/TIMEOUT_CYC combination");
    end

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   idx_q;
    logic [31:0]        data_buf;
    logic [31:0]        src_q;
    logic [31:0]        dst_q;
    logic [2:0]         op_q;
    logic               start_q;
    logic               idx_last;
    logic [31:0]        idx_offset;
    logic               wd_fire;

    assign idx_last   = (idx_q == CNT_W'(VEC_LEN - 1));
    // Byte offset of the current word; the base low bits pass through untouched.
    assign idx_offset = {{(30 - CNT_W){1'b0}}, idx_q, 2'b00};

`ifdef ACC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;

    assign wd_fire = (state_q == S_ST_POP) && !acc_out_valid &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // Count consecutive result-wait cycles; any accepted result or state exit clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if ((state_q == S_ST_POP) && !acc_out_valid && !wd_fire) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    // State register plus the operand/result datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            data_buf <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            op_q     <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (acc_instr_id) begin
                        src_q   <= acc_src_addr;
                        dst_q   <= acc_dst_addr;
                        op_q    <= acc_funct3;
                        idx_q   <= '0;
                        start_q <= 1'b1;
                    end
                end
                S_LD_REQ: begin
                    if (mem_ready) begin
                        data_buf <= mem_rdata;
                    end
                end
                S_LD_PUSH: begin
                    if (acc_in_ready) begin
                        idx_q <= idx_last ? '0 : idx_q + 1'b1;
                    end
                end
                S_ST_POP: begin
                    if (acc_out_valid) begin
                        data_buf <= acc_out_data;
                    end
                end
                S_ST_REQ: begin
                    if (mem_ready && !idx_last) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state selection and all handshake outputs, decoded from the current state.
    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        busy          = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = 32'h0;
        mem_wdata     = 32'h0;
        acc_in_valid  = 1'b0;
        acc_in_data   = 32'h0;
        acc_out_ready = 1'b0;
        acc_error     = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = acc_instr_id;
                if (acc_instr_id) begin
                    state_d = S_LD_REQ;
                end
            end
            S_LD_REQ: begin
                stall    = 1'b1;
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = src_q + idx_offset;
                if (mem_ready) begin
                    state_d = S_LD_PUSH;
                end
            end
            S_LD_PUSH: begin
                stall        = 1'b1;
                busy         = 1'b1;
                acc_in_valid = 1'b1;
                acc_in_data  = data_buf;
                if (acc_in_ready) begin
                    state_d = idx_last ? S_ST_POP : S_LD_REQ;
                end
            end
            S_ST_POP: begin
                stall         = 1'b1;
                busy          = 1'b1;
                acc_out_ready = 1'b1;
                if (acc_out_valid) begin
                    state_d = S_ST_REQ;
                end else if (wd_fire) begin
                    acc_error = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_ST_REQ: begin
                stall     = 1'b1;
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_q + idx_offset;
                mem_wdata = data_buf;
                if (mem_ready) begin
                    state_d = idx_last ? S_DONE : S_ST_POP;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign acc_start = start_q;
    assign acc_op    = op_q;

endmodule

// File: tb/tb_acc_dispatch_ctrl.sv
// tb/tb_acc_dispatch_ctrl.sv - randomized self-checking bench for acc_dispatch_ctrl
module tb_acc_dispatch_ctrl;

    localparam int N      = 8;
    localparam int TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_instr_id;
    logic [2:0]  acc_funct3;
    logic [31:0] acc_src_addr;
    logic [31:0] acc_dst_addr;
    logic        stall;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        acc_start;
    logic [2:0]  acc_op;
    logic        acc_in_valid;
    logic [31:0] acc_in_data;
    logic        acc_in_ready;
    logic        acc_out_valid;
    logic [31:0] acc_out_data;
    logic        acc_out_ready;
    logic        acc_error;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rd_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] acc_q[$];
    int          starts;
    int          errors_seen;
    int          err_pop_cycle;
    int          stall_cnt;

    always #5 clk = ~clk;

    // Data memory contents are a fixed function of the word address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign mem_rdata = mem_val(mem_addr);

    acc_dispatch_ctrl #(.VEC_LEN(N), .CNT_W(8), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .acc_instr_id(acc_instr_id), .acc_funct3(acc_funct3),
        .acc_src_addr(acc_src_addr), .acc_dst_addr(acc_dst_addr), .stall(stall), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .acc_start(acc_start), .acc_op(acc_op),
        .acc_in_valid(acc_in_valid), .acc_in_data(acc_in_data), .acc_in_ready(acc_in_ready),
        .acc_out_valid(acc_out_valid), .acc_out_data(acc_out_data), .acc_out_ready(acc_out_ready),
        .acc_error(acc_error)
    );

    // Runs one ACC instruction with an add-one accelerator model and checks it against the expected transfer lists.
    task automatic run_op(input logic [31:0] src, input logic [31:0] dst, input logic [2:0] op,
                          input bit bp, input bit no_result);
        bit          seen_busy = 0;
        bit          finished = 0;
        bit          pend_mem = 0;
        bit          pend_in = 0;
        logic [31:0] p_addr = 0, p_wdata = 0, p_in = 0;
        logic        p_we = 0;
        logic [31:0] d;
        int          pop_cycles = 0;
        bit          out_en;
        rd_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); acc_q.delete();
        starts = 0; errors_seen = 0; err_pop_cycle = -1; stall_cnt = 0;
        acc_src_addr = src; acc_dst_addr = dst; acc_funct3 = op;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc_instr_id = 1'b1;
            mem_ready    = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            acc_in_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            out_en       = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            acc_out_valid = !no_result && out_en && (acc_q.size() > 0);
            acc_out_data  = (acc_q.size() > 0) ? acc_q[0] : 32'h0;
            #1;
            if (cyc == 0) begin
                vectors++;
                if (stall !== 1'b1 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL accept_cycle stall=%0b busy=%0b required stall=1 busy=0", stall, busy);
                end
            end
            if (pend_mem) begin
                vectors++;
                if (mem_req !== 1'b1 || mem_addr !== p_addr || mem_we !== p_we || (p_we && mem_wdata !== p_wdata)) begin
                    miscompares++;
                    $display("FAIL mem_hold req=%0b addr=%h we=%0b wdata=%h required addr=%h we=%0b wdata=%h",
                             mem_req, mem_addr, mem_we, mem_wdata, p_addr, p_we, p_wdata);
                end
            end
            if (pend_in) begin
                vectors++;
                if (acc_in_valid !== 1'b1 || acc_in_data !== p_in) begin
                    miscompares++;
                    $display("FAIL in_hold valid=%0b data=%h required data=%h", acc_in_valid, acc_in_data, p_in);
                end
            end
            pend_mem = mem_req && !mem_ready;
            p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
            pend_in = acc_in_valid && !acc_in_ready;
            p_in = acc_in_data;
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    wr_addr_q.push_back(mem_addr);
                    wr_data_q.push_back(mem_wdata);
                end else begin
                    rd_q.push_back(mem_addr);
                end
            end
            if (acc_in_valid && acc_in_ready) acc_q.push_back(acc_in_data + 32'd1);
            if (acc_out_valid && acc_out_ready) d = acc_q.pop_front();
            if (acc_out_ready) pop_cycles++;
            if (acc_error) begin
                errors_seen++;
                err_pop_cycle = pop_cycles;
            end
            if (acc_start) begin
                starts++;
                vectors++;
                if (acc_op !== op) begin
                    miscompares++;
                    $display("FAIL acc_op got=%0d required=%0d", acc_op, op);
                end
            end
            if (stall) stall_cnt++;
            if (busy) seen_busy = 1;
            if (seen_busy && !stall) begin
                finished = 1;
                break;
            end
        end
        acc_instr_id = 1'b0; mem_ready = 1'b1; acc_in_ready = 1'b1; acc_out_valid = 1'b0;
        vectors++;
        if (!finished || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL completion finished=%0b busy=%0b required finished=1 busy=1 (DONE)", finished, busy);
        end
        vectors++;
        if (starts != 1) begin
            miscompares++;
            $display("FAIL start_pulses got=%0d required=1", starts);
        end
        vectors++;
        if (rd_q.size() != N) begin
            miscompares++;
            $display("FAIL read_count got=%0d required=%0d", rd_q.size(), N);
        end
        for (int i = 0; i < rd_q.size() && i < N; i++) begin
            logic [31:0] ea;
            ea = src + 32'(4 * i);
            vectors++;
            if (rd_q[i] !== ea) begin
                miscompares++;
                $display("FAIL read_addr[%0d] got=%h required=%h", i, rd_q[i], ea);
            end
        end
        if (no_result) begin
            vectors++;
            if (wr_addr_q.size() != 0 || errors_seen != 1 || err_pop_cycle != TO_CYC) begin
                miscompares++;
                $display("FAIL watchdog writes=%0d errors=%0d err_cycle=%0d required writes=0 errors=1 err_cycle=%0d",
                         wr_addr_q.size(), errors_seen, err_pop_cycle, TO_CYC);
            end
        end else begin
            vectors++;
            if (wr_addr_q.size() != N || errors_seen != 0) begin
                miscompares++;
                $display("FAIL write_count got=%0d errors=%0d required=%0d errors=0", wr_addr_q.size(), errors_seen, N);
            end
            for (int i = 0; i < wr_addr_q.size() && i < N; i++) begin
                logic [31:0] ea, ed;
                ea = dst + 32'(4 * i);
                ed = mem_val(src + 32'(4 * i)) + 32'd1;
                vectors++;
                if (wr_addr_q[i] !== ea || wr_data_q[i] !== ed) begin
                    miscompares++;
                    $display("FAIL write[%0d] got=%h:%h required=%h:%h", i, wr_addr_q[i], wr_data_q[i], ea, ed);
                end
            end
            vectors++;
            if (bp ? (stall_cnt < 4 * N + 1) : (stall_cnt != 4 * N + 1)) begin
                miscompares++;
                $display("FAIL stall_cycles got=%0d required=%0d", stall_cnt, 4 * N + 1);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({stall, busy, mem_req, mem_we, acc_start, acc_in_valid, acc_out_ready, acc_error} !== 8'h0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || acc_in_data !== 32'h0 || acc_op !== 3'h0) begin
            miscompares++;
            $display("FAIL %s stall=%0b busy=%0b req=%0b we=%0b addr=%h wdata=%h start=%0b op=%0d inv=%0b ind=%h outr=%0b err=%0b required all 0",
                     tag, stall, busy, mem_req, mem_we, mem_addr, mem_wdata, acc_start, acc_op,
                     acc_in_valid, acc_in_data, acc_out_ready, acc_error);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; acc_instr_id = 1'b0; acc_funct3 = 3'd0; acc_src_addr = 0; acc_dst_addr = 0;
        mem_ready = 1'b1; acc_in_ready = 1'b1; acc_out_valid = 1'b0; acc_out_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_all_zero("reset_state");
        rst = 1'b1;
    endtask

    task automatic test_basic;
        run_op(32'h100, 32'h200, 3'd3, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        for (int k = 0; k < 3; k++) run_op(32'h100, 32'h200, 3'($urandom_range(0, 7)), 1'b1, 1'b0);
    endtask

    task automatic test_wrap;
        run_op(32'hFFFF_FFF8, 32'h0000_0400, 3'd6, 1'b0, 1'b0);
        vectors++;
        if (rd_q.size() < 3 || rd_q[1] !== 32'hFFFF_FFFC || rd_q[2] !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_read got=%h required=00000000", (rd_q.size() > 2) ? rd_q[2] : 32'hX);
        end
    endtask

    task automatic test_back_to_back;
        run_op(32'h300, 32'h500, 3'd1, 1'b0, 1'b0);
        run_op(32'h700, 32'h900, 3'd4, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 4; k++)
            run_op($urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic test_reset_mid;
        bit hit = 0;
        acc_src_addr = 32'h1000; acc_dst_addr = 32'h2000; acc_funct3 = 3'd5;
        mem_ready = 1'b1; acc_in_ready = 1'b0; acc_out_valid = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            acc_instr_id = 1'b1;
            #1;
            if (acc_in_valid) begin
                hit = 1;
                break;
            end
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL reach_ld_push acc_in_valid never rose required=1");
        end
        rst = 1'b0; acc_instr_id = 1'b0;
        @(negedge clk); #1;
        check_all_zero("reset_mid_op");
        rst = 1'b1; acc_in_ready = 1'b1;
        run_op(32'h1000, 32'h2000, 3'd2, 1'b0, 1'b0);
    endtask

`ifdef ACC_TIMEOUT_EN
    task automatic test_watchdog;
        run_op(32'h100, 32'h200, 3'd7, 1'b0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef ACC_TIMEOUT_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
